// File: rtl/heat_node_writeback_if.sv
// -----------------------------------------------------------------------------
// heat_node_writeback_if
// Result stream from the stencil arithmetic into the writeback stage.
//   in_valid  : producer has an updated node value
//   in_ready  : writeback stage accepts this cycle
//   in_data   : float32 updated node value
//   in_idx    : node index of in_data
// master = stencil pipeline (producer), slave = writeback stage (consumer).
// -----------------------------------------------------------------------------
interface heat_node_writeback_if #(
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [IDX_W-1:0] in_idx;

  modport master (output in_valid, output in_data, output in_idx, input in_ready);
  modport slave  (input in_valid, input in_data, input in_idx, output in_ready);
endinterface

// File: rtl/heat_node_writeback.sv
// -----------------------------------------------------------------------------
// heat_node_writeback
// Last stage of the 1-D explicit heat-equation stencil pipeline. Updated
// interior node values are written into the shadow half of a double-buffered
// node array. Once every interior node of a sweep has been written, the banks
// swap and the new time step becomes visible on the registered read port.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_bus     : slave side of the result stream (valid/ready/data/idx)
//   rd_idx     : committed-array read address
//   rd_data    : committed node value, one cycle after rd_idx (0 if out of range)
//   step_done  : one-cycle pulse while a time step commits
//   step_cnt   : number of committed time steps (wraps at 2^16)
//   halted     : MAX_STEPS time steps have been committed
//   err        : sticky, an illegal node index was accepted
//   sw, led    : LED debug view, upper (sw=1) or lower (sw=0) half of rd_data
// -----------------------------------------------------------------------------
module heat_node_writeback #(
  parameter int          N_NODES   = 10,
  parameter int          IDX_W     = 4,
  parameter logic [31:0] INIT_VAL  = 32'h3E4CCCCD,
  parameter logic [31:0] BOUND_VAL = 32'h3F800000,
  parameter logic [15:0] MAX_STEPS = 16'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  heat_node_writeback_if.slave  in_bus,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [31:0]           rd_data,
  output logic                  step_done,
  output logic [15:0]           step_cnt,
  output logic                  halted,
  output logic                  err,
  input  logic                  sw,
  output logic [15:0]           led
);

  typedef enum logic [1:0] {
    COLLECT,
    SWAP,
    HALT
  } state_t;

  // Mask bits that must all be set before a sweep is complete: every node
  // except the two fixed boundary nodes.
  localparam logic [N_NODES-1:0] INTERIOR_MASK = {1'b0, {(N_NODES-2){1'b1}}, 1'b0};

  state_t state;
  state_t state_next;

  logic [31:0]        banks [2][N_NODES];
  logic               sel;
  logic               shadow;
  logic [N_NODES-1:0] mask;
  logic [N_NODES-1:0] set_bit;
  logic [N_NODES-1:0] wr_mask;
  logic [31:0]        wr_idx_ext;
  logic               accept;
  logic               idx_legal;
  logic               legal_wr;
  logic               illegal_wr;
  logic               sweep_complete;
  logic               halt_now;
  logic               rd_in_range;

  // Write-side decode. The shadow bank is the one not currently being served,
  // so writes and reads never touch the same bank.
  always_comb begin
    shadow         = ~sel;
    accept         = in_bus.in_valid & in_bus.in_ready;
    wr_idx_ext     = 32'(in_bus.in_idx);
    idx_legal      = (wr_idx_ext >= 32'd1) && (wr_idx_ext <= 32'(N_NODES - 2));
    legal_wr       = accept & idx_legal;
    illegal_wr     = accept & ~idx_legal;
    set_bit        = {{(N_NODES-1){1'b0}}, 1'b1} << in_bus.in_idx;
    wr_mask        = legal_wr ? (mask | set_bit) : mask;
    // A duplicate index leaves the mask unchanged, so completion is decided
    // by the set of distinct interior nodes written, not by the beat count.
    sweep_complete = legal_wr && ((wr_mask & INTERIOR_MASK) == INTERIOR_MASK);
    halt_now       = (MAX_STEPS != 16'd0) && ((step_cnt + 16'd1) == MAX_STEPS);
    rd_in_range    = 32'(rd_idx) < 32'(N_NODES);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic. SWAP always lasts a single cycle; the halt decision
  // looks at the count the commit is about to produce.
  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT: if (sweep_complete) state_next = SWAP;
      SWAP:    state_next = halt_now ? HALT : COLLECT;
      HALT:    state_next = HALT;
      default: state_next = COLLECT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_bus.in_ready = 1'b0;
    step_done       = 1'b0;
    halted          = 1'b0;
    unique case (state)
      COLLECT: in_bus.in_ready = 1'b1;
      SWAP:    step_done       = 1'b1;
      HALT:    halted          = 1'b1;
      default: ;
    endcase
  end

  // Node banks, bookkeeping and read port. Boundary entries are only ever
  // loaded by reset. At the end of SWAP the bank select flips; no copy into
  // the new shadow bank is needed because the next complete sweep rewrites
  // every interior node. The read samples the bank select before the flip,
  // so a read in the SWAP cycle still returns the old time step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int n = 0; n < N_NODES; n++) begin
          banks[b][n] <= ((n == 0) || (n == N_NODES - 1)) ? BOUND_VAL : INIT_VAL;
        end
      end
      sel      <= 1'b0;
      mask     <= '0;
      step_cnt <= '0;
      err      <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (legal_wr) begin
        banks[shadow][in_bus.in_idx] <= in_bus.in_data;
        mask                         <= wr_mask;
      end
      if (illegal_wr) begin
        err <= 1'b1;
      end
      if (state == SWAP) begin
        sel      <= ~sel;
        mask     <= '0;
        step_cnt <= step_cnt + 16'd1;
      end
      rd_data <= rd_in_range ? banks[sel][rd_idx] : '0;
    end
  end

  // LED debug view of the registered read data.
  assign led = sw ? rd_data[31:16] : rd_data[15:0];

endmodule

// File: tb/tb_heat_node_writeback.sv
// -----------------------------------------------------------------------------
// tb_heat_node_writeback
// Self-checking bench for heat_node_writeback (MAX_STEPS = 2). A transaction
// level model keeps the committed node values, the values staged for the
// running sweep and the set of nodes written so far; every cycle all DUT
// outputs are compared against it. Directed sweeps come first, followed by a
// randomized phase with occasional resets.
// -----------------------------------------------------------------------------
module tb_heat_node_writeback;

  localparam int          N_NODES   = 10;
  localparam int          IDX_W     = 4;
  localparam logic [31:0] INIT_VAL  = 32'h3E4CCCCD;
  localparam logic [31:0] BOUND_VAL = 32'h3F800000;
  localparam logic [15:0] MAX_STEPS = 16'd2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_data;
  logic             step_done;
  logic [15:0]      step_cnt;
  logic             halted;
  logic             err;
  logic             sw;
  logic [15:0]      led;

  heat_node_writeback_if #(.IDX_W(IDX_W)) bus ();

  heat_node_writeback #(
    .N_NODES  (N_NODES),
    .IDX_W    (IDX_W),
    .INIT_VAL (INIT_VAL),
    .BOUND_VAL(BOUND_VAL),
    .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bus   (bus),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .step_done(step_done),
    .step_cnt (step_cnt),
    .halted   (halted),
    .err      (err),
    .sw       (sw),
    .led      (led)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] committed [N_NODES];
  logic [31:0] pending   [N_NODES];
  bit          written   [N_NODES];
  int          steps;
  bit          m_err;
  bit          m_halted;
  bit          m_swap;
  logic [31:0] m_rd;
  logic        cur_sw;
  bit          last_accept;

  int tests_run    = 0;
  int tests_failed = 0;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model reset: both boundaries fixed, interior back to the initial value.
  task automatic modelReset();
    for (int n = 0; n < N_NODES; n++) begin
      committed[n] = ((n == 0) || (n == N_NODES - 1)) ? BOUND_VAL : INIT_VAL;
      pending[n]   = committed[n];
      written[n]   = 1'b0;
    end
    steps       = 0;
    m_err       = 1'b0;
    m_halted    = 1'b0;
    m_swap      = 1'b0;
    m_rd        = '0;
    last_accept = 1'b0;
  endtask

  // One clock edge of the model. The read sees the time step that is
  // committed before this edge; a pending commit is applied afterwards.
  task automatic modelEdge(input logic v, input logic [31:0] d,
                           input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] ri);
    int count;
    m_rd        = (int'(ri) < N_NODES) ? committed[ri] : 32'h0;
    last_accept = 1'b0;
    if (m_swap) begin
      for (int n = 1; n <= N_NODES - 2; n++) begin
        committed[n] = pending[n];
        written[n]   = 1'b0;
      end
      steps  = (steps + 1) % 65536;
      m_swap = 1'b0;
      if ((MAX_STEPS != 16'd0) && (steps == int'(MAX_STEPS))) m_halted = 1'b1;
    end else if (!m_halted && v) begin
      last_accept = 1'b1;
      if ((int'(idx) >= 1) && (int'(idx) <= N_NODES - 2)) begin
        pending[idx] = d;
        written[idx] = 1'b1;
        count = 0;
        for (int n = 1; n <= N_NODES - 2; n++) count += int'(written[n]);
        if (count == N_NODES - 2) m_swap = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("in_ready",  32'(bus.in_ready), 32'(!m_swap && !m_halted));
    checkOutput("step_done", 32'(step_done),    32'(m_swap));
    checkOutput("halted",    32'(halted),       32'(m_halted));
    checkOutput("err",       32'(err),          32'(m_err));
    checkOutput("step_cnt",  32'(step_cnt),     32'(steps));
    checkOutput("rd_data",   rd_data,           m_rd);
    checkOutput("led",       32'(led),          32'(cur_sw ? m_rd[31:16] : m_rd[15:0]));
  endtask

  // One cycle: drive at the falling edge, model the rising edge, check at the
  // next falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] ri,
                               input logic s);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_idx   = idx;
    rd_idx       = ri;
    sw           = s;
    cur_sw       = s;
    @(posedge clk);
    modelEdge(v, d, idx, ri);
    @(negedge clk);
    checkAll();
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic sendBeat(input logic [31:0] d, input logic [IDX_W-1:0] idx);
    int guard = 0;
    do begin
      applyStimulus(1'b1, d, idx, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      guard++;
    end while (!last_accept && guard < 20);
    checkOutput("beat_accepted", 32'(last_accept), 32'd1);
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++)
      applyStimulus(1'b0, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
  endtask

  task automatic readAll(input logic s);
    for (int i = 0; i < N_NODES; i++)
      applyStimulus(1'b0, 32'h0, 4'd0, 4'(i), s);
  endtask

  task automatic sweep(input logic [31:0] d, input int skip);
    for (int i = 1; i <= N_NODES - 2; i++)
      if (i != skip) sendBeat(d, 4'(i));
  endtask

  // Reset asserted at a falling edge and held across one rising edge.
  task automatic doReset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    modelReset();
    @(negedge clk);
    checkAll();
    rst = 1'b0;
  endtask

  initial begin
    bit               hold;
    logic             v;
    logic [31:0]      d;
    logic [IDX_W-1:0] idx;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_idx   = '0;
    rd_idx       = '0;
    sw           = 1'b0;
    cur_sw       = 1'b0;
    doReset();

    // Initial contents, both LED halves.
    readAll(1'b1);
    readAll(1'b0);

    // Full sweep of 0.5; reads in flight see the old step until the swap.
    sweep(32'h3F000000, 0);
    idle(3);
    readAll(1'b1);

    // Duplicate index: second value wins, node counted once. Second commit halts.
    sendBeat(32'h41200000, 4'd3);
    sendBeat(32'h3F800000, 4'd3);
    sweep(32'h3E800000, 3);
    idle(4);
    readAll(1'b0);

    // Reset mid-sweep restores everything; LED view of node 1.
    doReset();
    for (int i = 1; i <= 4; i++) sendBeat($urandom, 4'(i));
    doReset();
    applyStimulus(1'b0, 32'h0, 4'd1, 4'd1, 1'b1);
    applyStimulus(1'b0, 32'h0, 4'd1, 4'd1, 1'b0);
    readAll(1'b0);

    // Illegal indices set the sticky error; a legal sweep still commits.
    sendBeat(32'hDEADBEEF, 4'd0);
    sendBeat(32'hDEADBEEF, 4'd9);
    sendBeat(32'hDEADBEEF, 4'd15);
    readAll(1'b1);
    sweep($urandom, 0);
    idle(3);
    readAll(1'b0);

    // A beat held through the swap cycle lands in the next sweep.
    doReset();
    for (int i = 1; i <= N_NODES - 2; i++) sendBeat($urandom, 4'(i));
    sendBeat(32'h40490FDB, 4'd5);
    sweep(32'h3F400000, 5);
    idle(3);
    readAll(1'b1);

    // Randomized traffic; upstream holds an unaccepted beat.
    doReset();
    hold = 1'b0;
    v    = 1'b0;
    d    = '0;
    idx  = '0;
    for (int c = 0; c < 900; c++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 249) == 0) begin
        doReset();
        hold = 1'b0;
      end else begin
        if (!hold) begin
          v   = 1'($urandom_range(0, 9) < 7);
          d   = $urandom;
          idx = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, N_NODES - 2));
        end
        applyStimulus(v, d, idx, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        hold = v && !last_accept;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
